ahb_lite_sram_slave: RTL and testbench
======================================

// Module: ahb_lite_sram_slave
// PURPOSE
//  Parametrised AHB-Lite slave: byte-addressable SRAM behind the standard bus signal set.
//  Configurable data width, depth and wait states; supports byte/halfword/word(/dword) lanes.
//  Sits behind the decoder/mux; drives the completion handshake that the bus monitor checks.
// PARAMETERS
//  ADDR_W       32    HADDR width
//  DATA_W       32    HRDATA/HWDATA width; 32 or 64 only
//  DEPTH        1024  memory words of DATA_W bits; power of two not required
//  WAIT_STATES  0     HREADYOUT-low cycles inserted per OKAY data phase (0..15)
// PORTS
//  HCLK       in   1           bus clock; all logic on rising edge
//  HRESET     in   1           synchronous, active-high reset
//  HSEL       in   1           slave select from decoder
//  HADDR      in   ADDR_W      byte address (address phase)
//  HTRANS     in   2           IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
//  HWRITE     in   1           1 = write
//  HSIZE      in   3           transfer size, bytes = 1<<HSIZE
//  HWDATA     in   DATA_W      write data (data phase)
//  HREADY     in   1           bus-level ready (mux output)
//  HRDATA     out  DATA_W      read data (data phase)
//  HREADYOUT  out  1           this slave's ready
//  HRESP      out  1           0 OKAY, 1 ERROR
// BEHAVIOUR
//  - Reset: state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, captured phase cleared; memory not cleared.
//  - Sample: HSEL & HREADY & HTRANS[1] at rising edge captures addr/write/size/lanes. BUSY/IDLE -> OKAY, zero wait.
//  - Word index = HADDR[ADDR_W-1:log2(DATA_W/8)]; lanes little-endian from HSIZE + HADDR low bits.
//  - FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
//    IDLE/DATA/ERR2 with HREADY: valid sample -> ERR1 if error, WAIT if WAIT_STATES>0, else DATA; none -> IDLE.
//    WAIT: HREADYOUT=0, counter down from WAIT_STATES; reaching 1 -> DATA.
//    DATA: HREADYOUT=1, HRESP=0; write commits selected lanes of HWDATA at end of this cycle.
//    ERR1: HREADYOUT=0, HRESP=1 -> ERR2. ERR2: HREADYOUT=1, HRESP=1; nothing written.
//  - Read: HRDATA = mem[idx] combinational during WAIT/DATA, full word; else 0.
//  - Back-to-back: write then read of same word with WAIT_STATES=0 returns new data (write commits before read phase).
//  - Pipelined address phase accepted in the final DATA/ERR2 cycle; address phase during WAIT/ERR1 ignored (HREADY=0).
//  - HSIZE > log2(DATA_W/8): always ERROR, regardless of macro.
//  - HRESET mid-transfer: pending write dropped, FSM -> IDLE next edge.
// CONFIGURATION
//  AHB_SRAM_ERR_EN defined: idx >= DEPTH or address unaligned to HSIZE -> two-cycle ERROR, no write.
//  Undefined: idx wraps modulo DEPTH, address aligned down to HSIZE, OKAY response.
// STRUCTURE
//  ahb_pkg: htrans_t enum, HSIZE_* constants, HRESP_OKAY/ERROR, slv_state_t enum, lane-mask function.
//  Sub-module ahb_sram_array: DEPTH x DATA_W, async read, sync byte-enable write.
//  Top: FSM, wait counter, address-phase capture register, error decode.
// TESTING
//  1 WAIT_STATES=0: NONSEQ write 0x0000_0010 data 0xDEADBEEF, then read -> HRDATA=0xDEADBEEF, HREADYOUT never 0.
//  2 HSIZE=0 writes 0x11,0x22 to bytes 0x21,0x22 over word 0 -> read word 0x20 returns 0x00221100.
//  3 WAIT_STATES=3: single read -> HREADYOUT low exactly 3 cycles, data valid on 4th, OKAY.
//  4 ERR_EN, DEPTH=1024: write to 0x0000_1000 -> HRESP=1 two cycles, HREADYOUT 0 then 1; memory unchanged.
//  5 ERR_EN off: same write -> OKAY, lands at word 0; HSIZE=3 on DATA_W=32 -> ERROR.
//  6 HRESET asserted in WAIT of a write -> IDLE next cycle, HREADYOUT=1, target word unchanged.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and helpers for the SRAM slave: transfer/response encodings,
// slave FSM states and the little-endian byte-lane mask.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } slv_state_t;

  // A lane is enabled when it falls in the same size-aligned block as the offset,
  // which also aligns unaligned addresses down to the transfer size.
  function automatic logic [7:0] lane_mask(input logic [2:0] size, input logic [2:0] offs);
    logic [7:0] m;
    m = '0;
    for (int b = 0; b < 8; b++) begin
      m[b] = ((3'(b) >> size) == (offs >> size));
    end
    return m;
  endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// DEPTH x DATA_W storage: asynchronous read, synchronous write with per-byte enables.
module ahb_sram_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      addr,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: address-phase capture, wait-state FSM and error decode.
// Define AHB_SRAM_ERR_EN to turn out-of-range/unaligned accesses into ERROR responses.
module ahb_lite_sram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
);

  localparam int NB     = DATA_W / 8;
  localparam int BYTE_W = $clog2(NB);
  localparam int WIDX_W = ADDR_W - BYTE_W;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] MAX_SIZE = (DATA_W == 64) ? HSIZE_DWORD : HSIZE_WORD;

  slv_state_t        state, state_nxt;
  logic [3:0]        cnt;
  logic [IDX_W-1:0]  idx_p0, idx_d;
  logic              wr_p0;
  logic [NB-1:0]     be_p0, be_d;
  logic [WIDX_W-1:0] widx;
  logic [2:0]        offs;
  logic              size_err, addr_err, phase_ok, accept, we;
  logic [DATA_W-1:0] rdata;

  assign widx     = HADDR[ADDR_W-1:BYTE_W];
  assign offs     = 3'(HADDR[BYTE_W-1:0]);
  assign size_err = (HSIZE > MAX_SIZE);
  assign be_d     = NB'(lane_mask(HSIZE, offs));

`ifdef AHB_SRAM_ERR_EN
  logic [2:0] amask;
  assign amask    = ~(3'b111 << HSIZE);
  assign addr_err = (widx >= WIDX_W'(DEPTH)) || (|(amask & offs));
  assign idx_d    = widx[IDX_W-1:0];
`else
  assign addr_err = 1'b0;
  assign idx_d    = IDX_W'(widx % WIDX_W'(DEPTH));
`endif

  // New address phases are only taken when this slave is not stalling the bus.
  assign phase_ok = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
  assign accept   = HSEL && HREADY && phase_ok &&
                    ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DATA, S_ERR2: begin
        if (HREADY) begin
          if (accept) begin
            if (size_err || addr_err) state_nxt = S_ERR1;
            else if (WAIT_STATES > 0) state_nxt = S_WAIT;
            else                      state_nxt = S_DATA;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_WAIT:  if (cnt <= 4'd1) state_nxt = S_DATA;
      S_ERR1:  state_nxt = S_ERR2;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address-phase capture: p0 holds the transfer currently in its data phase.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state  <= S_IDLE;
      cnt    <= '0;
      idx_p0 <= '0;
      wr_p0  <= 1'b0;
      be_p0  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        idx_p0 <= idx_d;
        wr_p0  <= HWRITE;
        be_p0  <= be_d;
      end
      if (accept && (state_nxt == S_WAIT)) cnt <= 4'(WAIT_STATES);
      else if (state == S_WAIT)            cnt <= cnt - 4'd1;
    end
  end

  always_comb begin
    HREADYOUT = !((state == S_WAIT) || (state == S_ERR1));
    HRESP     = ((state == S_ERR1) || (state == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    HRDATA    = ((state == S_WAIT) || (state == S_DATA)) ? rdata : '0;
  end

  // Write lands at the end of the DATA cycle so a following read sees it.
  assign we = (state == S_DATA) && wr_p0 && !HRESET;

  ahb_sram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (HCLK),
    .we    (we),
    .addr  (idx_p0),
    .be    (be_p0),
    .wdata (HWDATA),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench for ahb_lite_sram_slave: a zero-wait and a three-wait instance on one bus.
module tb_ahb_lite_sram_slave;

  logic        HCLK = 1'b0;
  logic        rst0, rst3, sel0, sel3, hwrite;
  logic [31:0] haddr, hwdata, rdata0, rdata3;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        rdy0, rdy3, resp0, resp3;
  int          checks = 0;
  int          errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_lite_sram_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
    .HCLK(HCLK), .HRESET(rst0), .HSEL(sel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(rdy0),
    .HRDATA(rdata0), .HREADYOUT(rdy0), .HRESP(resp0));

  ahb_lite_sram_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(1024), .WAIT_STATES(3)) u_ws3 (
    .HCLK(HCLK), .HRESET(rst3), .HSEL(sel3), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(rdy3),
    .HRDATA(rdata3), .HREADYOUT(rdy3), .HRESP(resp3));

  task automatic tick;
    @(posedge HCLK); #1;
  endtask

  task automatic addr_ph(input logic s0, input logic s3, input logic [31:0] a,
                         input logic w, input logic [2:0] sz);
    sel0 = s0; sel3 = s3; haddr = a; htrans = 2'b10; hwrite = w; hsize = sz;
  endtask

  task automatic bus_idle;
    sel0 = 1'b0; sel3 = 1'b0; htrans = 2'b00; hwrite = 1'b0;
  endtask

  task automatic wr0(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    addr_ph(1'b1, 1'b0, a, 1'b1, sz); tick;
    bus_idle; hwdata = d; tick;
  endtask

  task automatic rd0(input logic [31:0] a, output logic [31:0] d);
    addr_ph(1'b1, 1'b0, a, 1'b0, 3'd2); tick;
    d = rdata0; bus_idle; tick;
  endtask

  task automatic wr3(input logic [31:0] a, input logic [31:0] d, output logic to);
    int n;
    n = 0;
    addr_ph(1'b0, 1'b1, a, 1'b1, 3'd2); tick;
    bus_idle; hwdata = d;
    while (rdy3 !== 1'b1 && n < 20) begin tick; n++; end
    to = (n >= 20);
    tick;
  endtask

  task automatic rd3(input logic [31:0] a, output logic [31:0] d, output int lows,
                     output logic r, output logic to);
    lows = 0;
    addr_ph(1'b0, 1'b1, a, 1'b0, 3'd2); tick;
    bus_idle;
    while (rdy3 !== 1'b1 && lows < 20) begin lows++; tick; end
    to = (lows >= 20); d = rdata3; r = resp3;
    tick;
  endtask

  task automatic test_reset;
    rst0 = 1'b1; rst3 = 1'b1; bus_idle; haddr = '0; hsize = 3'd2; hwdata = '0;
    tick; tick;
    checks++; if (rdy0 !== 1'b1)   begin errors++; $display("FAIL reset_rdy0: got %b expected 1", rdy0); end
    checks++; if (resp0 !== 1'b0)  begin errors++; $display("FAIL reset_resp0: got %b expected 0", resp0); end
    checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL reset_rdata0: got %h expected 0", rdata0); end
    checks++; if (rdy3 !== 1'b1)   begin errors++; $display("FAIL reset_rdy3: got %b expected 1", rdy3); end
    checks++; if (resp3 !== 1'b0)  begin errors++; $display("FAIL reset_resp3: got %b expected 0", resp3); end
    checks++; if (rdata3 !== 32'h0) begin errors++; $display("FAIL reset_rdata3: got %h expected 0", rdata3); end
    rst0 = 1'b0; rst3 = 1'b0; tick;
  endtask

  task automatic test_back_to_back;
    int lowseen;
    lowseen = 0;
    addr_ph(1'b1, 1'b0, 32'h0000_0010, 1'b1, 3'd2); tick;
    if (rdy0 !== 1'b1) lowseen++;
    checks++; if (resp0 !== 1'b0) begin errors++; $display("FAIL b2b_wr_resp: got %b expected 0", resp0); end
    hwdata = 32'hDEADBEEF; addr_ph(1'b1, 1'b0, 32'h0000_0010, 1'b0, 3'd2); tick;
    if (rdy0 !== 1'b1) lowseen++;
    checks++; if (rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_rdata: got %h expected deadbeef", rdata0); end
    checks++; if (resp0 !== 1'b0) begin errors++; $display("FAIL b2b_rd_resp: got %b expected 0", resp0); end
    bus_idle; tick;
    if (rdy0 !== 1'b1) lowseen++;
    checks++; if (lowseen !== 0) begin errors++; $display("FAIL b2b_ready: low %0d cycles expected 0", lowseen); end
    checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL b2b_idle_rdata: got %h expected 0", rdata0); end
  endtask

  task automatic test_byte_lanes;
    logic [31:0] d;
    wr0(32'h20, 3'd2, 32'h0);
    wr0(32'h21, 3'd0, 32'h1111_1111);
    wr0(32'h22, 3'd0, 32'h2222_2222);
    rd0(32'h20, d);
    checks++; if (d !== 32'h0022_1100) begin errors++; $display("FAIL byte_lanes: got %h expected 00221100", d); end
    wr0(32'h30, 3'd2, 32'h1234_5678);
    wr0(32'h32, 3'd1, 32'hABCD_ABCD);
    rd0(32'h30, d);
    checks++; if (d !== 32'hABCD_5678) begin errors++; $display("FAIL half_lanes: got %h expected abcd5678", d); end
  endtask

  task automatic test_wait_states;
    logic [31:0] d;
    logic        to, r;
    int          lows;
    wr3(32'h40, 32'hCAFE_F00D, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL ws_write_timeout: got %b expected 0", to); end
    rd3(32'h40, d, lows, r, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL ws_read_timeout: got %b expected 0", to); end
    checks++; if (lows !== 3) begin errors++; $display("FAIL ws_low_cycles: got %0d expected 3", lows); end
    checks++; if (d !== 32'hCAFE_F00D) begin errors++; $display("FAIL ws_rdata: got %h expected cafef00d", d); end
    checks++; if (r !== 1'b0) begin errors++; $display("FAIL ws_resp: got %b expected 0", r); end
  endtask

  task automatic test_error;
    logic [31:0] d;
    wr0(32'h0, 3'd2, 32'h5A5A_5A5A);
    wr0(32'h8, 3'd2, 32'h0BAD_F00D);
    addr_ph(1'b1, 1'b0, 32'h0000_1000, 1'b1, 3'd2); tick;
`ifdef AHB_SRAM_ERR_EN
    checks++; if (resp0 !== 1'b1) begin errors++; $display("FAIL range_err1_resp: got %b expected 1", resp0); end
    checks++; if (rdy0 !== 1'b0)  begin errors++; $display("FAIL range_err1_rdy: got %b expected 0", rdy0); end
    hwdata = 32'h0102_0304; bus_idle; tick;
    checks++; if (resp0 !== 1'b1) begin errors++; $display("FAIL range_err2_resp: got %b expected 1", resp0); end
    checks++; if (rdy0 !== 1'b1)  begin errors++; $display("FAIL range_err2_rdy: got %b expected 1", rdy0); end
    tick;
    checks++; if (resp0 !== 1'b0) begin errors++; $display("FAIL range_after_resp: got %b expected 0", resp0); end
    rd0(32'h0, d);
    checks++; if (d !== 32'h5A5A_5A5A) begin errors++; $display("FAIL range_nowrite: got %h expected 5a5a5a5a", d); end
`else
    checks++; if (resp0 !== 1'b0) begin errors++; $display("FAIL wrap_resp: got %b expected 0", resp0); end
    checks++; if (rdy0 !== 1'b1)  begin errors++; $display("FAIL wrap_rdy: got %b expected 1", rdy0); end
    hwdata = 32'h0102_0304; bus_idle; tick;
    rd0(32'h0, d);
    checks++; if (d !== 32'h0102_0304) begin errors++; $display("FAIL wrap_word0: got %h expected 01020304", d); end
`endif
    addr_ph(1'b1, 1'b0, 32'h8, 1'b1, 3'd3); tick;
    checks++; if (resp0 !== 1'b1) begin errors++; $display("FAIL size_err1_resp: got %b expected 1", resp0); end
    checks++; if (rdy0 !== 1'b0)  begin errors++; $display("FAIL size_err1_rdy: got %b expected 0", rdy0); end
    hwdata = 32'hFFFF_FFFF; bus_idle; tick;
    checks++; if (resp0 !== 1'b1) begin errors++; $display("FAIL size_err2_resp: got %b expected 1", resp0); end
    checks++; if (rdy0 !== 1'b1)  begin errors++; $display("FAIL size_err2_rdy: got %b expected 1", rdy0); end
    tick;
    rd0(32'h8, d);
    checks++; if (d !== 32'h0BAD_F00D) begin errors++; $display("FAIL size_nowrite: got %h expected 0badf00d", d); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    logic        to, r;
    int          lows;
    wr3(32'h44, 32'h1122_3344, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL rstmid_pre_timeout: got %b expected 0", to); end
    addr_ph(1'b0, 1'b1, 32'h44, 1'b1, 3'd2); tick;
    checks++; if (rdy3 !== 1'b0) begin errors++; $display("FAIL rstmid_wait: got %b expected 0", rdy3); end
    hwdata = 32'hFFFF_FFFF; bus_idle; rst3 = 1'b1; tick;
    checks++; if (rdy3 !== 1'b1)    begin errors++; $display("FAIL rstmid_rdy: got %b expected 1", rdy3); end
    checks++; if (resp3 !== 1'b0)   begin errors++; $display("FAIL rstmid_resp: got %b expected 0", resp3); end
    checks++; if (rdata3 !== 32'h0) begin errors++; $display("FAIL rstmid_rdata: got %h expected 0", rdata3); end
    rst3 = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    checks++; if (rdy3 !== 1'b1) begin errors++; $display("FAIL rstmid_stays_idle: got %b expected 1", rdy3); end
    rd3(32'h44, d, lows, r, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL rstmid_rd_timeout: got %b expected 0", to); end
    checks++; if (d !== 32'h1122_3344) begin errors++; $display("FAIL rstmid_word: got %h expected 11223344", d); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_back_to_back;
    test_byte_lanes;
    test_wait_states;
    test_error;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
